// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding an 8N1 UART transmitter for the data-memory dump path.
// Flow control back to the data memory is the registered FIFO-full flag.
module uart_tx_buffer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       SYS_reset,
    input  logic       DMEM_transmit_request,
    input  logic [7:0] DMEM_data_transmit,
    output logic       transmitter_buffer_full,
    output logic       UART_tx,
    output logic       transmitter_idle
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        r_state;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [CW-1:0] r_baud;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;

    logic w_full;
    logic w_not_empty;
    logic w_baud_done;
    logic w_push;
    logic w_pop;

    assign w_full      = (r_count == COUNT_FULL);
    assign w_not_empty = (r_count != '0);
    assign w_baud_done = (r_baud == BAUD_LAST);
    assign w_push      = DMEM_transmit_request && !w_full;

    // Pops happen only where a new frame starts: from IDLE, or at the
    // end of a stop bit so consecutive frames run without an idle gap.
    assign w_pop = w_not_empty &&
                   ((r_state == S_IDLE) ||
                    ((r_state == S_STOP) && w_baud_done));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= DMEM_data_transmit;
        end
    end

    always_ff @(posedge clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_baud_done) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                S_STOP: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= r_mem[r_rd_ptr];
                            r_state <= S_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign UART_tx                 = r_tx;
    assign transmitter_buffer_full = w_full;
    assign transmitter_idle        = (r_state == S_IDLE) && !w_not_empty;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Scoreboard bench for uart_tx_buffer with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Accepted bytes are queued at the handshake; a line receiver pops and compares.
module tb_uart_tx_buffer;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       SYS_reset;
    logic       req;
    logic [7:0] din;
    logic       full;
    logic       tx;
    logic       idle;

    int         npass = 0;
    int         ntotal = 0;
    int         cyc = 0;
    logic [7:0] exp_q [$];

    uart_tx_buffer #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk                    (clk),
        .SYS_reset              (SYS_reset),
        .DMEM_transmit_request  (req),
        .DMEM_data_transmit     (din),
        .transmitter_buffer_full(full),
        .UART_tx                (tx),
        .transmitter_idle       (idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    // Receives one 8N1 frame sampled on falling edges; ok drops on a
    // timeout or on any sample that disagrees within a bit period.
    task automatic rx_frame(output logic [7:0] b, output int t0,
                            output bit ok);
        int   n;
        logic bitv;
        ok = 1'b1;
        b  = 8'h00;
        t0 = -1;
        n  = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx !== 1'b0 && n < 300);
        if (tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        t0 = cyc;
        for (int k = 1; k < CPB; k++) begin
            @(negedge clk);
            if (tx !== 1'b0) ok = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bitv = tx;
            b[i] = bitv;
            for (int k = 1; k < CPB; k++) begin
                @(negedge clk);
                if (tx !== bitv) ok = 1'b0;
            end
        end
        for (int k = 0; k < CPB; k++) begin
            @(negedge clk);
            if (tx !== 1'b1) ok = 1'b0;
        end
    endtask

    task automatic do_reset();
        req       = 1'b0;
        din       = 8'h00;
        SYS_reset = 1'b1;
        repeat (2) @(negedge clk);
        SYS_reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        SYS_reset = 1'b1;
        req       = 1'b0;
        din       = 8'h00;
        #1;
        ntotal++;
        if (tx !== 1'b1) $display("FAIL reset_tx got %b exp 1", tx);
        else npass++;
        ntotal++;
        if (full !== 1'b0) $display("FAIL reset_full got %b exp 0", full);
        else npass++;
        ntotal++;
        if (idle !== 1'b1) $display("FAIL reset_idle got %b exp 1", idle);
        else npass++;
        @(negedge clk);
        SYS_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [7:0] b;
        logic [7:0] e;
        int         t0;
        int         tp;
        bit         ok;
        @(negedge clk);
        req = 1'b1;
        din = 8'hA5;
        if (!full) exp_q.push_back(din);
        @(negedge clk);
        req = 1'b0;
        tp  = cyc;
        ntotal++;
        if (tx !== 1'b1) $display("FAIL single_tx_before_pop got %b exp 1", tx);
        else npass++;
        ntotal++;
        if (idle !== 1'b0) $display("FAIL single_idle_busy got %b exp 0", idle);
        else npass++;
        rx_frame(b, t0, ok);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = 8'hxx;
        ntotal++;
        if (ok !== 1'b1) $display("FAIL single_frame_shape got %b exp 1", ok);
        else npass++;
        ntotal++;
        if (b !== e) $display("FAIL single_data got %h exp %h", b, e);
        else npass++;
        ntotal++;
        if (t0 !== tp + 1) $display("FAIL single_latency got %0d exp %0d", t0, tp + 1);
        else npass++;
        @(negedge clk);
        ntotal++;
        if (idle !== 1'b1) $display("FAIL single_idle_end got %b exp 1", idle);
        else npass++;
    endtask

    task automatic test_stream();
        logic [7:0] b;
        logic [7:0] e;
        int         t0;
        int         tprev;
        bit         ok;
        int         acc;
        int         first_full;
        int         guard;
        int         lows;
        acc        = 0;
        first_full = -1;
        tprev      = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    req   = 1'b1;
                    din   = 8'(i + 1);
                    guard = 0;
                    while (full === 1'b1 && guard < 400) begin
                        @(negedge clk);
                        guard++;
                    end
                    exp_q.push_back(din);
                    acc++;
                    @(negedge clk);
                    if (full === 1'b1 && first_full < 0) first_full = acc;
                end
                req = 1'b0;
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    rx_frame(b, t0, ok);
                    if (exp_q.size() != 0) e = exp_q.pop_front();
                    else e = 8'hxx;
                    ntotal++;
                    if (ok !== 1'b1) $display("FAIL stream_shape[%0d] got %b exp 1", i, ok);
                    else npass++;
                    ntotal++;
                    if (b !== e) $display("FAIL stream_data[%0d] got %h exp %h", i, b, e);
                    else npass++;
                    if (i > 0) begin
                        ntotal++;
                        if (t0 - tprev !== FRAME)
                            $display("FAIL stream_gap[%0d] got %0d exp %0d", i, t0 - tprev, FRAME);
                        else npass++;
                    end
                    tprev = t0;
                end
            end
        join
        // One byte is already in the shifter when the 4 FIFO slots fill.
        ntotal++;
        if (first_full !== DEPTH + 1)
            $display("FAIL stream_full_point got %0d exp %0d", first_full, DEPTH + 1);
        else npass++;
        ntotal++;
        if (exp_q.size() !== 0) $display("FAIL stream_leftover got %0d exp 0", exp_q.size());
        else npass++;
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        ntotal++;
        if (lows !== 0) $display("FAIL stream_no_dup got %0d low samples exp 0", lows);
        else npass++;
        ntotal++;
        if (idle !== 1'b1) $display("FAIL stream_idle_end got %b exp 1", idle);
        else npass++;
    endtask

    task automatic test_full_pop();
        logic [7:0] b;
        logic [7:0] e;
        int         ts [6];
        int         t0;
        bit         ok;
        int         guard;
        int         t_drop;
        int         g;
        t_drop = -1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    req   = 1'b1;
                    din   = 8'(8'h10 + i);
                    guard = 0;
                    while (full === 1'b1 && guard < 400) begin
                        @(negedge clk);
                        guard++;
                    end
                    exp_q.push_back(din);
                    @(negedge clk);
                end
                req = 1'b0;
            end
            begin
                g = 0;
                while (full !== 1'b1 && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                g = 0;
                while (full !== 1'b0 && g < 200) begin
                    @(negedge clk);
                    g++;
                end
                t_drop = cyc;
                @(negedge clk);
                ntotal++;
                if (full !== 1'b1) $display("FAIL fullpop_refill got %b exp 1", full);
                else npass++;
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    rx_frame(b, t0, ok);
                    ts[i] = t0;
                    if (exp_q.size() != 0) e = exp_q.pop_front();
                    else e = 8'hxx;
                    ntotal++;
                    if (ok !== 1'b1 || b !== e)
                        $display("FAIL fullpop_frame[%0d] got %h ok=%b exp %h", i, b, ok, e);
                    else npass++;
                end
            end
        join
        ntotal++;
        if (t_drop !== ts[1])
            $display("FAIL fullpop_drop_cycle got %0d exp %0d", t_drop, ts[1]);
        else npass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int   offs [2];
        int   bad;
        logic start_seen;
        offs[0] = 17;
        offs[1] = 1;
        for (int r = 0; r < 2; r++) begin
            do_reset();
            req = 1'b1;
            din = 8'h3C;
            @(negedge clk);
            din = 8'h11;
            @(negedge clk);
            din = 8'h22;
            start_seen = tx;
            @(negedge clk);
            req = 1'b0;
            ntotal++;
            if (start_seen !== 1'b0) $display("FAIL midreset_start[%0d] got %b exp 0", r, start_seen);
            else npass++;
            repeat (offs[r] - 1) @(negedge clk);
            #1;
            SYS_reset = 1'b1;
            #1;
            ntotal++;
            if (tx !== 1'b1) $display("FAIL midreset_tx[%0d] got %b exp 1", r, tx);
            else npass++;
            ntotal++;
            if (full !== 1'b0) $display("FAIL midreset_full[%0d] got %b exp 0", r, full);
            else npass++;
            ntotal++;
            if (idle !== 1'b1) $display("FAIL midreset_idle[%0d] got %b exp 1", r, idle);
            else npass++;
            exp_q.delete();
            @(negedge clk);
            SYS_reset = 1'b0;
            bad = 0;
            repeat (100) begin
                @(negedge clk);
                if (tx !== 1'b1 || idle !== 1'b1) bad++;
            end
            ntotal++;
            if (bad !== 0) $display("FAIL midreset_quiet[%0d] got %0d bad samples exp 0", r, bad);
            else npass++;
        end
    endtask

    task automatic test_stop_push();
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] e;
        int         t1;
        int         t2;
        bit         ok1;
        bit         ok2;
        int         g;
        @(negedge clk);
        req = 1'b1;
        din = 8'h00;
        if (!full) exp_q.push_back(din);
        @(negedge clk);
        req = 1'b0;
        fork
            begin
                g = 0;
                do begin
                    @(negedge clk);
                    g++;
                end while (tx !== 1'b0 && g < 50);
                repeat (36) @(negedge clk);
                req = 1'b1;
                din = 8'hFF;
                if (!full) exp_q.push_back(din);
                @(negedge clk);
                req = 1'b0;
            end
            begin
                rx_frame(b1, t1, ok1);
                rx_frame(b2, t2, ok2);
            end
        join
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = 8'hxx;
        ntotal++;
        if (ok1 !== 1'b1 || b1 !== e) $display("FAIL stoppush_first got %h ok=%b exp %h", b1, ok1, e);
        else npass++;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = 8'hxx;
        ntotal++;
        if (ok2 !== 1'b1 || b2 !== e) $display("FAIL stoppush_second got %h ok=%b exp %h", b2, ok2, e);
        else npass++;
        ntotal++;
        if (t2 - t1 !== FRAME) $display("FAIL stoppush_gap got %0d exp %0d", t2 - t1, FRAME);
        else npass++;
        ntotal++;
        if (idle !== 1'b0) $display("FAIL stoppush_busy_79 got %b exp 0", idle);
        else npass++;
        @(negedge clk);
        ntotal++;
        if (idle !== 1'b1 || tx !== 1'b1)
            $display("FAIL stoppush_end_80 got idle=%b tx=%b exp 1 1", idle, tx);
        else npass++;
    endtask

    task automatic test_quiet();
        int bad;
        do_reset();
        bad = 0;
        repeat (100) begin
            din = 8'($urandom_range(0, 255));
            @(negedge clk);
            if (tx !== 1'b1 || idle !== 1'b1) bad++;
        end
        ntotal++;
        if (bad !== 0) $display("FAIL quiet_line got %0d bad samples exp 0", bad);
        else npass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_full_pop();
        test_reset_mid_frame();
        test_stop_push();
        test_quiet();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
